// File: rtl/dps_bus_initiator.sv
// dps_bus_initiator
// CPU-side master for the DPS bus. Core load/store requests are queued in a
// small FIFO and issued one at a time over the DPS request/busy handshake.
// Writes are posted. Reads hold the request path until the DPS returns data
// or a timeout expires, so completions reach the core in issue order.
// The block also terminates the DPS interrupt line. It latches the IRQ number,
// acks the DPS for one cycle, and holds the interrupt for the core until the
// core acks it.
//
// Handshakes:
//   core -> FIFO : a request is taken on any cycle with iCORE_REQ && !oCORE_BUSY.
//                  A request offered while busy is dropped, not retried.
//   FIFO -> DPS  : oDPS_REQ is only raised when !iDPS_BUSY. A raised oDPS_REQ
//                  is therefore accepted in that same cycle.
//   DPS -> core  : iDPS_VALID is honoured only while a read is outstanding.
//                  oCORE_VALID pulses for one cycle, and oCORE_ERR qualifies it.
//   IRQ          : DPS holds iDPS_IRQ_REQ until oDPS_IRQ_ACK. The core holds the
//                  interrupt until it pulses iCORE_IRQ_ACK.
//
// Ports:
//   iCLOCK, inRESET                         clock, async active-low reset
//   iCORE_REQ/RW/ADDR/DATA, oCORE_BUSY      core request side
//   oCORE_VALID/DATA/ERR                    read completion to core
//   oDPS_REQ/RW/ADDR/DATA, iDPS_BUSY        DPS request side
//   iDPS_VALID/DATA                         DPS read data
//   iDPS_IRQ_REQ/NUM, oDPS_IRQ_ACK          DPS interrupt side
//   oCORE_IRQ_VALID/NUM, iCORE_IRQ_ACK      core interrupt side
module dps_bus_initiator #(
    parameter int REQ_DEPTH = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iCORE_REQ,
    output logic        oCORE_BUSY,
    input  logic        iCORE_RW,
    input  logic [31:0] iCORE_ADDR,
    input  logic [31:0] iCORE_DATA,
    output logic        oCORE_VALID,
    output logic [31:0] oCORE_DATA,
    output logic        oCORE_ERR,
    output logic        oDPS_REQ,
    input  logic        iDPS_BUSY,
    output logic        oDPS_RW,
    output logic [31:0] oDPS_ADDR,
    output logic [31:0] oDPS_DATA,
    input  logic        iDPS_VALID,
    input  logic [31:0] iDPS_DATA,
    input  logic        iDPS_IRQ_REQ,
    input  logic [5:0]  iDPS_IRQ_NUM,
    output logic        oDPS_IRQ_ACK,
    output logic        oCORE_IRQ_VALID,
    output logic [5:0]  oCORE_IRQ_NUM,
    input  logic        iCORE_IRQ_ACK
);
    localparam int               PTR_W    = $clog2(REQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(REQ_DEPTH);
    // The counter starts at 0 on the first RD_WAIT cycle, so TIMEOUT-1 marks
    // the TIMEOUT-th waiting cycle.
    localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;
    localparam logic [0:0] IRQ_IDLE   = 1'b0;
    localparam logic [0:0] IRQ_HOLD   = 1'b1;

    // Request FIFO storage. It is not reset, because the pointers and count
    // define which entries are valid.
    logic              fifo_rw   [REQ_DEPTH];
    logic [31:0]       fifo_addr [REQ_DEPTH];
    logic [31:0]       fifo_data [REQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [0:0]        req_state;
    logic [15:0]       to_cnt;
    logic [0:0]        irq_state;

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              dps_req;
    logic              timed_out;

    assign fifo_empty = (count == '0);
    assign oCORE_BUSY = (count == CNT_FULL);
    assign push       = iCORE_REQ && !oCORE_BUSY;

    // Issue only from IDLE. At most one read is ever outstanding.
    assign dps_req    = (req_state == ST_IDLE) && !fifo_empty && !iDPS_BUSY;
    assign pop        = dps_req;
    assign timed_out  = (to_cnt == TO_LAST);

    // The address, data and direction are don't-care without a request. They
    // are driven to 0 so that the bus stays quiet, including during reset.
    assign oDPS_REQ   = dps_req;
    assign oDPS_RW    = dps_req && fifo_rw[rd_ptr];
    assign oDPS_ADDR  = dps_req ? fifo_addr[rd_ptr] : 32'd0;
    assign oDPS_DATA  = dps_req ? fifo_data[rd_ptr] : 32'd0;

    always_ff @(posedge iCLOCK) begin
        if (push) begin
            fifo_rw[wr_ptr]   <= iCORE_RW;
            fifo_addr[wr_ptr] <= iCORE_ADDR;
            fifo_data[wr_ptr] <= iCORE_DATA;
        end
    end

    // Pointers wrap naturally because REQ_DEPTH is a power of two.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;
        end
    end

    // Request FSM. Writes are posted and leave the FSM in IDLE. A read parks
    // it in RD_WAIT until data arrives or the timeout fires. Data takes
    // priority over a timeout that expires in the same cycle.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            req_state   <= ST_IDLE;
            to_cnt      <= '0;
            oCORE_VALID <= 1'b0;
            oCORE_DATA  <= 32'd0;
            oCORE_ERR   <= 1'b0;
        end else begin
            oCORE_VALID <= 1'b0;
            oCORE_ERR   <= 1'b0;
            if (req_state == ST_IDLE) begin
                if (dps_req && !fifo_rw[rd_ptr]) begin
                    req_state <= ST_RD_WAIT;
                    to_cnt    <= '0;
                end
            end else begin
                if (iDPS_VALID) begin
                    oCORE_VALID <= 1'b1;
                    oCORE_DATA  <= iDPS_DATA;
                    req_state   <= ST_IDLE;
                end else if (timed_out) begin
                    oCORE_VALID <= 1'b1;
                    oCORE_DATA  <= 32'd0;
                    oCORE_ERR   <= 1'b1;
                    req_state   <= ST_IDLE;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end

    // IRQ FSM. While the core holds an interrupt, the DPS line is not sampled.
    // A second request therefore waits until the core acks the first one.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            irq_state       <= IRQ_IDLE;
            oDPS_IRQ_ACK    <= 1'b0;
            oCORE_IRQ_VALID <= 1'b0;
            oCORE_IRQ_NUM   <= 6'd0;
        end else begin
            oDPS_IRQ_ACK <= 1'b0;
            if (irq_state == IRQ_IDLE) begin
                if (iDPS_IRQ_REQ) begin
                    oDPS_IRQ_ACK    <= 1'b1;
                    oCORE_IRQ_VALID <= 1'b1;
                    oCORE_IRQ_NUM   <= iDPS_IRQ_NUM;
                    irq_state       <= IRQ_HOLD;
                end
            end else if (iCORE_IRQ_ACK) begin
                oCORE_IRQ_VALID <= 1'b0;
                irq_state       <= IRQ_IDLE;
            end
        end
    end
endmodule
